// File: rtl/axi_mem_window_bridge_if.sv
// AXI4 bundle (AR/AW/W/B/R) used on both sides of axi_mem_window_bridge.
interface axi_mem_window_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 6
);
  localparam int STRB_W = DATA_W / 8;

  logic              ar_valid, ar_ready;
  logic [ADDR_W-1:0] ar_addr;
  logic [ID_W-1:0]   ar_id;
  logic [7:0]        ar_len;
  logic [2:0]        ar_size;
  logic [1:0]        ar_burst;
  logic              ar_lock;
  logic [3:0]        ar_cache;
  logic [2:0]        ar_prot;
  logic [3:0]        ar_qos;

  logic              aw_valid, aw_ready;
  logic [ADDR_W-1:0] aw_addr;
  logic [ID_W-1:0]   aw_id;
  logic [7:0]        aw_len;
  logic [2:0]        aw_size;
  logic [1:0]        aw_burst;
  logic              aw_lock;
  logic [3:0]        aw_cache;
  logic [2:0]        aw_prot;
  logic [3:0]        aw_qos;

  logic              w_valid, w_ready;
  logic [DATA_W-1:0] w_data;
  logic [STRB_W-1:0] w_strb;
  logic              w_last;

  logic              b_valid, b_ready;
  logic [ID_W-1:0]   b_id;
  logic [1:0]        b_resp;

  logic              r_valid, r_ready;
  logic [ID_W-1:0]   r_id;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  logic              r_last;

  modport master (
    output ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
    input  ar_ready,
    output aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    input  b_valid, b_id, b_resp,
    output b_ready,
    input  r_valid, r_id, r_data, r_resp, r_last,
    output r_ready
  );

  modport slave (
    input  ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
    output ar_ready,
    input  aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output b_valid, b_id, b_resp,
    input  b_ready,
    output r_valid, r_id, r_data, r_resp, r_last,
    input  r_ready
  );
endinterface

// File: rtl/axi_mem_window_bridge.sv
// Rocket io_mem_axi -> PS S_AXI HP bridge: window remap, AR/AW slices, outstanding limit, local DECERR.
// Optional MEM_WINDOW_ERR_LOG_EN adds err_count/err_addr for rejected requests.
module axi_mem_window_bridge #(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 64,
  parameter int              ID_W     = 6,
  parameter int              WIN_BITS = 28,
  parameter logic [ADDR_W-1:0] SRC_BASE = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] DST_BASE = 32'h1000_0000,
  parameter int              MAX_OUT  = 8
) (
  input  logic clock,
  input  logic reset_n,
  axi_mem_window_bridge_if.slave  s,
  axi_mem_window_bridge_if.master m
`ifdef MEM_WINDOW_ERR_LOG_EN
  ,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] err_addr
`endif
);
  localparam int AX_W = ADDR_W + ID_W + 8 + 3 + 2 + 1 + 4 + 3 + 4;

  localparam logic [1:0] RD_IDLE = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] RD_ERR  = 2'd2;

  localparam logic [2:0] WR_IDLE  = 3'd0;
  localparam logic [2:0] WR_WAIT  = 3'd1;
  localparam logic [2:0] WR_SINK  = 3'd2;
  localparam logic [2:0] WR_DRAIN = 3'd3;
  localparam logic [2:0] WR_RESP  = 3'd4;

  function automatic logic [ADDR_W-1:0] remap(input logic [ADDR_W-1:0] a);
    return {DST_BASE[ADDR_W-1:WIN_BITS], a[WIN_BITS-1:0]};
  endfunction

  logic            run;
  logic [1:0]      rd_state;
  logic [2:0]      wr_state;
  logic            ar_full, aw_full;
  logic [AX_W-1:0] ar_q, aw_q;
  logic [7:0]      rd_cnt, wr_cnt;
  logic [8:0]      wbursts;
  logic [ID_W-1:0] err_rid, err_bid;
  logic [7:0]      err_rlen, rbeat;

  logic ar_legal, aw_legal, ar_hs, aw_hs, m_ar_hs, m_aw_hs, m_r_done, m_b_hs, m_w_done;
  logic err_r, err_b, sink, fwd;

  assign ar_legal = s.ar_addr[ADDR_W-1:WIN_BITS] == SRC_BASE[ADDR_W-1:WIN_BITS];
  assign aw_legal = s.aw_addr[ADDR_W-1:WIN_BITS] == SRC_BASE[ADDR_W-1:WIN_BITS];
  assign ar_hs    = s.ar_valid & s.ar_ready;
  assign aw_hs    = s.aw_valid & s.aw_ready;
  assign m_ar_hs  = m.ar_valid & m.ar_ready;
  assign m_aw_hs  = m.aw_valid & m.aw_ready;
  assign m_r_done = m.r_valid & m.r_ready & m.r_last;
  assign m_b_hs   = m.b_valid & m.b_ready;
  assign m_w_done = m.w_valid & m.w_ready & m.w_last;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) run <= 1'b0;
    else          run <= 1'b1;
  end

  // A held slice entry counts against the limit so rd_cnt/wr_cnt can never exceed MAX_OUT.
  assign s.ar_ready = run && rd_state == RD_IDLE && (!ar_full || m.ar_ready) &&
                      ({1'b0, rd_cnt} + {8'd0, ar_full} < 9'(MAX_OUT));
  assign s.aw_ready = run && wr_state == WR_IDLE && (!aw_full || m.aw_ready) &&
                      ({1'b0, wr_cnt} + {8'd0, aw_full} < 9'(MAX_OUT));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ar_full <= 1'b0;
      ar_q    <= '0;
      aw_full <= 1'b0;
      aw_q    <= '0;
    end else begin
      if (ar_hs && ar_legal) begin
        ar_full <= 1'b1;
        ar_q    <= {remap(s.ar_addr), s.ar_id, s.ar_len, s.ar_size, s.ar_burst,
                    s.ar_lock, s.ar_cache, s.ar_prot, s.ar_qos};
      end else if (m_ar_hs) begin
        ar_full <= 1'b0;
      end
      if (aw_hs && aw_legal) begin
        aw_full <= 1'b1;
        aw_q    <= {remap(s.aw_addr), s.aw_id, s.aw_len, s.aw_size, s.aw_burst,
                    s.aw_lock, s.aw_cache, s.aw_prot, s.aw_qos};
      end else if (m_aw_hs) begin
        aw_full <= 1'b0;
      end
    end
  end

  assign m.ar_valid = ar_full;
  assign {m.ar_addr, m.ar_id, m.ar_len, m.ar_size, m.ar_burst,
          m.ar_lock, m.ar_cache, m.ar_prot, m.ar_qos} = ar_q;
  assign m.aw_valid = aw_full;
  assign {m.aw_addr, m.aw_id, m.aw_len, m.aw_size, m.aw_burst,
          m.aw_lock, m.aw_cache, m.aw_prot, m.aw_qos} = aw_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      wbursts <= '0;
    end else begin
      case ({m_ar_hs, m_r_done})
        2'b10:   rd_cnt <= rd_cnt + 8'd1;
        2'b01:   rd_cnt <= rd_cnt - 8'd1;
        default: rd_cnt <= rd_cnt;
      endcase
      case ({m_aw_hs, m_b_hs})
        2'b10:   wr_cnt <= wr_cnt + 8'd1;
        2'b01:   wr_cnt <= wr_cnt - 8'd1;
        default: wr_cnt <= wr_cnt;
      endcase
      case ({aw_hs && aw_legal, m_w_done})
        2'b10:   wbursts <= wbursts + 9'd1;
        2'b01:   wbursts <= wbursts - 9'd1;
        default: wbursts <= wbursts;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_state <= RD_IDLE;
      err_rid  <= '0;
      err_rlen <= '0;
      rbeat    <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: if (ar_hs && !ar_legal) begin
          rd_state <= RD_WAIT;
          err_rid  <= s.ar_id;
          err_rlen <= s.ar_len;
          rbeat    <= '0;
        end
        RD_WAIT: if (rd_cnt == 8'd0 && !ar_full) rd_state <= RD_ERR;
        RD_ERR: if (s.r_ready) begin
          rbeat <= rbeat + 8'd1;
          if (rbeat == err_rlen) rd_state <= RD_IDLE;
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_state <= WR_IDLE;
      err_bid  <= '0;
    end else begin
      case (wr_state)
        WR_IDLE: if (aw_hs && !aw_legal) begin
          wr_state <= WR_WAIT;
          err_bid  <= s.aw_id;
        end
        WR_WAIT:  if (wbursts == 9'd0) wr_state <= WR_SINK;
        WR_SINK:  if (s.w_valid && s.w_last) wr_state <= WR_DRAIN;
        WR_DRAIN: if (wr_cnt == 8'd0 && !aw_full) wr_state <= WR_RESP;
        WR_RESP:  if (s.b_ready) wr_state <= WR_IDLE;
        default:  wr_state <= WR_IDLE;
      endcase
    end
  end

  // PS responses keep flowing while an error waits for older bursts to retire;
  // only the DECERR beats themselves take over the upstream R/B channel.
  assign err_r     = rd_state == RD_ERR;
  assign s.r_valid = err_r ? 1'b1 : m.r_valid;
  assign s.r_id    = err_r ? err_rid : m.r_id;
  assign s.r_data  = err_r ? '0 : m.r_data;
  assign s.r_resp  = err_r ? 2'b11 : m.r_resp;
  assign s.r_last  = err_r ? (rbeat == err_rlen) : m.r_last;
  assign m.r_ready = !err_r && s.r_ready;

  assign err_b     = wr_state == WR_RESP;
  assign s.b_valid = err_b ? 1'b1 : m.b_valid;
  assign s.b_id    = err_b ? err_bid : m.b_id;
  assign s.b_resp  = err_b ? 2'b11 : m.b_resp;
  assign m.b_ready = !err_b && s.b_ready;

  assign sink      = wr_state == WR_SINK;
  assign fwd       = wbursts != 9'd0 && !sink;
  assign m.w_valid = fwd && s.w_valid;
  assign m.w_data  = s.w_data;
  assign m.w_strb  = s.w_strb;
  assign m.w_last  = s.w_last;
  assign s.w_ready = sink || (fwd && m.w_ready);

`ifdef MEM_WINDOW_ERR_LOG_EN
  logic        rej_ar, rej_aw;
  logic [16:0] err_sum;
  assign rej_ar  = ar_hs && !ar_legal;
  assign rej_aw  = aw_hs && !aw_legal;
  assign err_sum = {1'b0, err_count} + {16'd0, rej_ar} + {16'd0, rej_aw};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= '0;
      err_addr  <= '0;
    end else begin
      err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      if (rej_ar)      err_addr <= s.ar_addr;
      else if (rej_aw) err_addr <= s.aw_addr;
    end
  end
`endif
endmodule

// File: tb/tb_axi_mem_window_bridge.sv
// Directed self-checking bench for axi_mem_window_bridge (default MAX_OUT=8 instance plus a MAX_OUT=2 instance).
module tb_axi_mem_window_bridge;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  always #5 clock = ~clock;

  axi_mem_window_bridge_if #(.ADDR_W(32), .DATA_W(64), .ID_W(6)) u ();
  axi_mem_window_bridge_if #(.ADDR_W(32), .DATA_W(64), .ID_W(6)) p ();
  axi_mem_window_bridge_if #(.ADDR_W(32), .DATA_W(64), .ID_W(6)) u2 ();
  axi_mem_window_bridge_if #(.ADDR_W(32), .DATA_W(64), .ID_W(6)) p2 ();

`ifdef MEM_WINDOW_ERR_LOG_EN
  logic [15:0] err_count_a, err_count_b;
  logic [31:0] err_addr_a, err_addr_b;
`endif

  axi_mem_window_bridge #(.MAX_OUT(8)) dut (
    .clock(clock), .reset_n(reset_n), .s(u.slave), .m(p.master)
`ifdef MEM_WINDOW_ERR_LOG_EN
    , .err_count(err_count_a), .err_addr(err_addr_a)
`endif
  );

  axi_mem_window_bridge #(.MAX_OUT(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .s(u2.slave), .m(p2.master)
`ifdef MEM_WINDOW_ERR_LOG_EN
    , .err_count(err_count_b), .err_addr(err_addr_b)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [5:0] i, input logic [7:0] l);
    int unsigned n = 0;
    @(negedge clock);
    u.ar_addr = a; u.ar_id = i; u.ar_len = l; u.ar_valid = 1'b1;
    #1;
    while (!u.ar_ready && n < 50) begin @(negedge clock); #1; n++; end
    check("ar_hs", 64'(u.ar_ready), 64'd1);
    @(posedge clock); #1;
    u.ar_valid = 1'b0;
  endtask

  task automatic aw_send(input logic [31:0] a, input logic [5:0] i, input logic [7:0] l);
    int unsigned n = 0;
    @(negedge clock);
    u.aw_addr = a; u.aw_id = i; u.aw_len = l; u.aw_valid = 1'b1;
    #1;
    while (!u.aw_ready && n < 50) begin @(negedge clock); #1; n++; end
    check("aw_hs", 64'(u.aw_ready), 64'd1);
    @(posedge clock); #1;
    u.aw_valid = 1'b0;
  endtask

  task automatic w_beat(input logic [63:0] d, input logic last, input logic exp_fwd);
    int unsigned n = 0;
    @(negedge clock);
    u.w_data = d; u.w_strb = 8'hFF; u.w_last = last; u.w_valid = 1'b1;
    #1;
    while (!u.w_ready && n < 50) begin @(negedge clock); #1; n++; end
    check("w_hs", 64'(u.w_ready), 64'd1);
    check("w_fwd", 64'(p.w_valid), 64'(exp_fwd));
    check("w_data", p.w_data, d);
    @(posedge clock); #1;
    u.w_valid = 1'b0;
  endtask

  task automatic ps_b(input logic [5:0] i);
    @(negedge clock);
    p.b_valid = 1'b1; p.b_id = i; p.b_resp = 2'b00; u.b_ready = 1'b1;
    #1;
    check("b_pass_valid", 64'(u.b_valid), 64'd1);
    check("b_pass_id", 64'(u.b_id), 64'(i));
    check("b_pass_resp", 64'(u.b_resp), 64'd0);
    @(posedge clock); #1;
    p.b_valid = 1'b0; u.b_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    u.ar_valid = 0; u.ar_addr = 0; u.ar_id = 0; u.ar_len = 0; u.ar_size = 3'd3; u.ar_burst = 2'd1;
    u.ar_lock = 0; u.ar_cache = 4'h3; u.ar_prot = 3'd2; u.ar_qos = 4'd5;
    u.aw_valid = 0; u.aw_addr = 0; u.aw_id = 0; u.aw_len = 0; u.aw_size = 3'd3; u.aw_burst = 2'd1;
    u.aw_lock = 0; u.aw_cache = 4'h3; u.aw_prot = 3'd2; u.aw_qos = 4'd5;
    u.w_valid = 0; u.w_data = 0; u.w_strb = 0; u.w_last = 0; u.b_ready = 0; u.r_ready = 0;
    p.ar_ready = 0; p.aw_ready = 0; p.w_ready = 0; p.b_valid = 0; p.b_id = 0; p.b_resp = 0;
    p.r_valid = 0; p.r_id = 0; p.r_data = 0; p.r_resp = 0; p.r_last = 0;
    u2.ar_valid = 0; u2.ar_addr = 0; u2.ar_id = 0; u2.ar_len = 0; u2.ar_size = 3'd3; u2.ar_burst = 2'd1;
    u2.ar_lock = 0; u2.ar_cache = 0; u2.ar_prot = 0; u2.ar_qos = 0;
    u2.aw_valid = 0; u2.aw_addr = 0; u2.aw_id = 0; u2.aw_len = 0; u2.aw_size = 3'd3; u2.aw_burst = 2'd1;
    u2.aw_lock = 0; u2.aw_cache = 0; u2.aw_prot = 0; u2.aw_qos = 0;
    u2.w_valid = 0; u2.w_data = 0; u2.w_strb = 0; u2.w_last = 0; u2.b_ready = 0; u2.r_ready = 0;
    p2.ar_ready = 0; p2.aw_ready = 0; p2.w_ready = 0; p2.b_valid = 0; p2.b_id = 0; p2.b_resp = 0;
    p2.r_valid = 0; p2.r_id = 0; p2.r_data = 0; p2.r_resp = 0; p2.r_last = 0;

    // reset state
    repeat (2) @(negedge clock);
    #1;
    check("rst_ar_ready", 64'(u.ar_ready), 64'd0);
    check("rst_aw_ready", 64'(u.aw_ready), 64'd0);
    check("rst_w_ready", 64'(u.w_ready), 64'd0);
    check("rst_m_ar_valid", 64'(p.ar_valid), 64'd0);
    check("rst_m_aw_valid", 64'(p.aw_valid), 64'd0);
`ifdef MEM_WINDOW_ERR_LOG_EN
    check("rst_err_count", 64'(err_count_a), 64'd0);
`endif
    @(negedge clock); reset_n = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    check("idle_ar_ready", 64'(u.ar_ready), 64'd1);
    check("idle_aw_ready", 64'(u.aw_ready), 64'd1);
    check("idle_w_ready", 64'(u.w_ready), 64'd0);

    // 1: legal read, remap and R passthrough
    ar_send(32'h8000_1040, 6'd1, 8'd3);
    @(negedge clock); #1;
    check("t1_m_ar_valid", 64'(p.ar_valid), 64'd1);
    check("t1_m_ar_addr", 64'(p.ar_addr), 64'h1000_1040);
    check("t1_m_ar_id", 64'(p.ar_id), 64'd1);
    check("t1_m_ar_len", 64'(p.ar_len), 64'd3);
    check("t1_m_ar_fields", 64'({p.ar_size, p.ar_burst, p.ar_lock, p.ar_cache, p.ar_prot, p.ar_qos}),
          64'({3'd3, 2'd1, 1'b0, 4'h3, 3'd2, 4'd5}));
    p.ar_ready = 1'b1;
    @(posedge clock); #1; p.ar_ready = 1'b0;
    @(negedge clock); #1;
    check("t1_m_ar_drained", 64'(p.ar_valid), 64'd0);
    for (int b = 0; b < 4; b++) begin
      @(negedge clock);
      p.r_valid = 1'b1; p.r_id = 6'd1; p.r_data = 64'hA000 + 64'(b); p.r_resp = 2'b00;
      p.r_last = (b == 3); u.r_ready = 1'b1;
      #1;
      check("t1_r_valid", 64'(u.r_valid), 64'd1);
      check("t1_r_data", u.r_data, 64'hA000 + 64'(b));
      check("t1_r_id", 64'(u.r_id), 64'd1);
      check("t1_r_resp", 64'(u.r_resp), 64'd0);
      check("t1_r_last", 64'(u.r_last), 64'(b == 3));
      check("t1_m_r_ready", 64'(p.r_ready), 64'd1);
      @(posedge clock); #1;
    end
    p.r_valid = 1'b0; p.r_last = 1'b0; u.r_ready = 1'b0;

    // 2: legal single-beat write at the top of the window
    p.aw_ready = 1'b1; p.w_ready = 1'b1;
    aw_send(32'h8FFF_FFC0, 6'd2, 8'd0);
    @(negedge clock); #1;
    check("t2_m_aw_valid", 64'(p.aw_valid), 64'd1);
    check("t2_m_aw_addr", 64'(p.aw_addr), 64'h1FFF_FFC0);
    check("t2_m_aw_id", 64'(p.aw_id), 64'd2);
    w_beat(64'h1122_3344_5566_7788, 1'b1, 1'b1);
    ps_b(6'd2);

    // 3: out-of-window read answered locally
    ar_send(32'h9000_0000, 6'd5, 8'd7);
    for (int b = 0; b < 8; b++) begin
      @(negedge clock);
      u.r_ready = 1'b1;
      n = 0;
      #1;
      while (!u.r_valid && n < 20) begin @(negedge clock); #1; n++; end
      check("t3_r_valid", 64'(u.r_valid), 64'd1);
      check("t3_r_id", 64'(u.r_id), 64'd5);
      check("t3_r_data", u.r_data, 64'd0);
      check("t3_r_resp", 64'(u.r_resp), 64'd3);
      check("t3_r_last", 64'(u.r_last), 64'(b == 7));
      check("t3_m_r_ready", 64'(p.r_ready), 64'd0);
      check("t3_no_m_ar", 64'(p.ar_valid), 64'd0);
      @(posedge clock);
    end
    @(negedge clock); u.r_ready = 1'b0; #1;
    check("t3_r_done", 64'(u.r_valid), 64'd0);
    check("t3_ar_ready_back", 64'(u.ar_ready), 64'd1);

    // 4: illegal write ordered behind two legal writes
    aw_send(32'h8000_0100, 6'd10, 8'd0);
    w_beat(64'h0100, 1'b1, 1'b1);
    aw_send(32'h8000_0200, 6'd11, 8'd0);
    w_beat(64'h0200, 1'b1, 1'b1);
    aw_send(32'h7000_0000, 6'd3, 8'd1);
    w_beat(64'hDEAD_0001, 1'b0, 1'b0);
    w_beat(64'hDEAD_0002, 1'b1, 1'b0);
    u.b_ready = 1'b1;
    repeat (2) begin
      @(negedge clock); #1;
      check("t4_b_held", 64'(u.b_valid), 64'd0);
    end
    u.b_ready = 1'b0;
    ps_b(6'd10);
    @(negedge clock); #1;
    check("t4_b_held_one", 64'(u.b_valid), 64'd0);
    ps_b(6'd11);
    @(negedge clock); u.b_ready = 1'b1;
    n = 0;
    #1;
    while (!u.b_valid && n < 20) begin @(negedge clock); #1; n++; end
    check("t4_err_b_valid", 64'(u.b_valid), 64'd1);
    check("t4_err_b_id", 64'(u.b_id), 64'd3);
    check("t4_err_b_resp", 64'(u.b_resp), 64'd3);
    check("t4_m_b_ready", 64'(p.b_ready), 64'd0);
    @(posedge clock); #1; u.b_ready = 1'b0;
    @(negedge clock); #1;
    check("t4_b_done", 64'(u.b_valid), 64'd0);
    check("t4_aw_ready_back", 64'(u.aw_ready), 64'd1);
    p.aw_ready = 1'b0; p.w_ready = 1'b0;

    // 5: outstanding limit on the MAX_OUT=2 instance
    p2.ar_ready = 1'b1;
    @(negedge clock);
    u2.ar_addr = 32'h8000_0000; u2.ar_id = 6'd1; u2.ar_valid = 1'b1;
    #1; check("t5_ar1_ready", 64'(u2.ar_ready), 64'd1);
    @(posedge clock); #1; u2.ar_addr = 32'h8000_0040; u2.ar_id = 6'd2;
    @(negedge clock); #1; check("t5_ar2_ready", 64'(u2.ar_ready), 64'd1);
    @(posedge clock); #1; u2.ar_addr = 32'h8000_0080; u2.ar_id = 6'd3;
    repeat (3) begin
      @(negedge clock); #1; check("t5_ar3_stall", 64'(u2.ar_ready), 64'd0);
    end
    @(negedge clock);
    p2.r_valid = 1'b1; p2.r_id = 6'd1; p2.r_last = 1'b1; u2.r_ready = 1'b1;
    #1;
    check("t5_stall_at_rlast", 64'(u2.ar_ready), 64'd0);
    check("t5_r_id", 64'(u2.r_id), 64'd1);
    @(posedge clock); #1; p2.r_valid = 1'b0;
    @(negedge clock); #1; check("t5_ar3_resume", 64'(u2.ar_ready), 64'd1);
    @(posedge clock); #1; u2.ar_valid = 1'b0;
    @(negedge clock);
    p2.r_valid = 1'b1; p2.r_id = 6'd2; p2.r_last = 1'b1;
    @(posedge clock); #1; p2.r_valid = 1'b0; u2.r_ready = 1'b0;

    // 6: simultaneous AR/AW rejects, then asynchronous reset mid-burst
    @(negedge clock);
    u2.ar_addr = 32'h0000_0000; u2.ar_id = 6'd7; u2.ar_len = 8'd0; u2.ar_valid = 1'b1;
    u2.aw_addr = 32'h0000_0004; u2.aw_id = 6'd8; u2.aw_len = 8'd0; u2.aw_valid = 1'b1;
    #1;
    check("t6_ar_ready", 64'(u2.ar_ready), 64'd1);
    check("t6_aw_ready", 64'(u2.aw_ready), 64'd1);
    @(posedge clock); #1; u2.ar_valid = 1'b0; u2.aw_valid = 1'b0;
    @(negedge clock); #1;
    check("t6_ar_busy", 64'(u2.ar_ready), 64'd0);
`ifdef MEM_WINDOW_ERR_LOG_EN
    check("t6_err_count", 64'(err_count_b), 64'd2);
    check("t6_err_addr", 64'(err_addr_b), 64'd0);
`endif
    ar_send(32'h8000_0040, 6'd9, 8'd3);
    @(negedge clock); #1;
    check("t6_pre_m_ar_valid", 64'(p.ar_valid), 64'd1);
    check("t6_pre_sink_ready", 64'(u2.w_ready), 64'd1);
    reset_n = 1'b0;
    p.r_valid = 1'b0; p.b_valid = 1'b0; p2.r_valid = 1'b0; p2.b_valid = 1'b0;
    #1;
    check("t6_rst_m_ar_valid", 64'(p.ar_valid), 64'd0);
    check("t6_rst_m_aw_valid", 64'(p.aw_valid), 64'd0);
    check("t6_rst_m_w_valid", 64'(p.w_valid), 64'd0);
    check("t6_rst_s_r_valid", 64'(u2.r_valid), 64'd0);
    check("t6_rst_s_b_valid", 64'(u2.b_valid), 64'd0);
    check("t6_rst_w_ready", 64'(u2.w_ready), 64'd0);
    check("t6_rst_ar_ready", 64'(u.ar_ready), 64'd0);
    #20;
    @(negedge clock); reset_n = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    check("t6_post_m_ar_valid", 64'(p.ar_valid), 64'd0);
    check("t6_post_r_valid", 64'(u2.r_valid), 64'd0);
    check("t6_post_b_valid", 64'(u2.b_valid), 64'd0);
    check("t6_post_ar_ready", 64'(u2.ar_ready), 64'd1);
`ifdef MEM_WINDOW_ERR_LOG_EN
    check("t6_post_err_count", 64'(err_count_b), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
